// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single outstanding word reads,
// and hands {instruction, pc} to decode; redirects squash anything in flight.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    PC_INCREMENT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;

  function automatic logic [ADDR_WIDTH-1:0] pc_step(input logic [ADDR_WIDTH-1:0] cur);
    return cur + ADDR_WIDTH'(PC_INCREMENT);
  endfunction

  // A redirect masks both handshakes in the same cycle so nothing stale escapes.
  assign imem_req_addr  = pc;
  assign imem_req_valid = reset_n && (state == S_REQ)  && !redirect_valid;
  assign inst_valid     = reset_n && (state == S_HOLD) && !redirect_valid;
  assign busy           = reset_n && ((state == S_WAIT) || (state == S_DRAIN));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      inst_data <= '0;
      inst_pc   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid)      pc    <= redirect_pc;
          else if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= imem_resp_valid ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid) begin
            inst_data <= imem_resp_data;
            inst_pc   <= pc;
            pc        <= pc_step(pc);
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          // The response still owed to the squashed request must be swallowed here.
          if (redirect_valid)  pc    <= redirect_pc;
          if (imem_resp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    inst_ready      = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({imem_req_valid, inst_valid, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=000", i, {imem_req_valid, inst_valid, busy});
      end
      tick();
    end
    idle_inputs();
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req_valid, busy} !== 2'b10) begin
      n_err++; $display("FAIL reset_release_valid_busy got=%b exp=10", {imem_req_valid, busy});
    end
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_pc got=%h exp=00000000", imem_req_addr);
    end
    n_cmp++;
    if ({inst_data, inst_pc} !== 64'h0) begin
      n_err++; $display("FAIL reset_inst_regs got=%h/%h exp=0/0", inst_data, inst_pc);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_data [3];
    logic [31:0] exp_addr;
    exp_data[0] = 32'hDEAD_0000;
    exp_data[1] = 32'hDEAD_0004;
    exp_data[2] = 32'hDEAD_0008;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_addr = 32'(k * 4);
      #1;
      n_cmp++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, exp_addr}) begin
        n_err++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, exp_addr);
      end
      tick();
      imem_resp_valid = 1'b1;
      imem_resp_data  = imem_req_addr ^ 32'hDEAD_0000;
      #1;
      n_cmp++;
      if ({busy, imem_req_valid, inst_valid} !== 3'b100) begin
        n_err++; $display("FAIL seq_wait k=%0d got=%b exp=100", k, {busy, imem_req_valid, inst_valid});
      end
      tick();
      imem_resp_valid = 1'b0;
      #1;
      n_cmp++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, exp_addr, exp_data[k]}) begin
        n_err++; $display("FAIL seq_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, exp_addr, exp_data[k]);
      end
      tick();
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({imem_req_valid, imem_req_addr, busy} !== {1'b1, 32'h0, 1'b0}) begin
        n_err++; $display("FAIL stall_req cyc=%0d got=%b/%h/%b exp=1/00000000/0", i, imem_req_valid, imem_req_addr, busy);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if ({busy, imem_req_valid} !== 2'b10) begin
      n_err++; $display("FAIL stall_accept got=%b exp=10", {busy, imem_req_valid});
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({inst_valid, inst_data, inst_pc} !== {1'b1, 32'h1234_5678, 32'h0}) begin
        n_err++; $display("FAIL hold_inst cyc=%0d got=%b/%h/%h exp=1/12345678/00000000", i, inst_valid, inst_data, inst_pc);
      end
      n_cmp++;
      if ({imem_req_valid, imem_req_addr} !== {1'b0, 32'h4}) begin
        n_err++; $display("FAIL hold_noreq cyc=%0d got=%b/%h exp=0/00000004", i, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) begin
      n_err++; $display("FAIL hold_release got=%b/%h/%b exp=1/00000004/0", imem_req_valid, imem_req_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    n_cmp++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      n_err++; $display("FAIL rdw_mask got=%b exp=00", {imem_req_valid, inst_valid});
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, imem_req_valid, imem_req_addr} !== {2'b10, 32'h100}) begin
      n_err++; $display("FAIL rdw_drain got=%b/%b/%h exp=1/0/00000100", busy, imem_req_valid, imem_req_addr);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rdw_stale_inst got=%b exp=0", inst_valid);
    end
    tick();
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr, inst_valid, busy} !== {1'b1, 32'h100, 2'b00}) begin
      n_err++; $display("FAIL rdw_next got=%b/%h/%b/%b exp=1/00000100/0/0", imem_req_valid, imem_req_addr, inst_valid, busy);
    end
    // Redirect landing on the same cycle as the response: no drain phase.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h100;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, busy, imem_req_addr} !== {2'b10, 32'h100}) begin
      n_err++; $display("FAIL rdw_coincident got=%b/%b/%h exp=1/0/00000100", imem_req_valid, busy, imem_req_addr);
    end
    tick();
    #1;
    n_cmp++;
    if ({inst_valid, imem_req_valid} !== 2'b01) begin
      n_err++; $display("FAIL rdw_coincident_noinst got=%b exp=01", {inst_valid, imem_req_valid});
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BAD_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h200;
    inst_ready      = 1'b1;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rdh_squash got=%b exp=0", inst_valid);
    end
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin
      n_err++; $display("FAIL rdh_next got=%b/%h/%b exp=1/00000200/0", imem_req_valid, imem_req_addr, inst_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    #1;
    n_cmp++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'hFFFF_FFFC, 32'h13}) begin
      n_err++; $display("FAIL wrap_inst got=%b/%h/%h exp=1/fffffffc/00000013", inst_valid, inst_pc, inst_data);
    end
    tick();
    inst_ready = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if ({busy, imem_req_addr} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL rstmid_wait got=%b/%h exp=1/00000040", busy, imem_req_addr);
    end
    reset_n = 1'b0;
    tick();
    reset_n         = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_AAAA;
    #1;
    n_cmp++;
    if ({busy, imem_req_valid, imem_req_addr} !== {2'b01, 32'h0}) begin
      n_err++; $display("FAIL rstmid_after got=%b/%b/%h exp=0/1/00000000", busy, imem_req_valid, imem_req_addr);
    end
    tick();
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({inst_valid, busy, imem_req_valid, imem_req_addr} !== {3'b001, 32'h0}) begin
      n_err++; $display("FAIL rstmid_stale got=%b/%b/%b/%h exp=0/0/1/00000000", inst_valid, busy, imem_req_valid, imem_req_addr);
    end
  endtask

  // Model tracks the fetch stream as transactions: the address the next fetch
  // must use, whether a fetch is owed a response (and still wanted), and the
  // instruction waiting for decode.
  task automatic test_random();
    logic [31:0] exp_pc, req_addr, held_pc, held_data, mem_data;
    bit          outstanding, live, held, mem_pend, rv, exp_rv, exp_iv;
    int          mem_cnt, delivered;
    do_reset();
    exp_pc = 32'h0; req_addr = '0; held_pc = '0; held_data = '0; mem_data = '0;
    outstanding = 0; live = 0; held = 0; mem_pend = 0; mem_cnt = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rv = 0;
      imem_resp_data = $urandom;
      if (mem_pend && mem_cnt == 0) begin
        rv = 1; mem_pend = 0; imem_resp_data = mem_data;
      end else if (mem_pend) begin
        mem_cnt--;
      end else if ($urandom_range(15) == 0) begin
        rv = 1;
      end
      imem_resp_valid = rv;
      imem_req_ready  = ($urandom_range(3) != 0);
      inst_ready      = ($urandom_range(1) == 1);
      redirect_valid  = ($urandom_range(9) == 0);
      redirect_pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      #1;
      exp_rv = !outstanding && !held && !redirect_valid;
      exp_iv = held && !redirect_valid;
      n_cmp++;
      if ({imem_req_valid, inst_valid, busy} !== {exp_rv, exp_iv, outstanding}) begin
        n_err++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {imem_req_valid, inst_valid, busy}, {exp_rv, exp_iv, outstanding});
      end
      n_cmp++;
      if (imem_req_addr !== exp_pc) begin
        n_err++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc);
      end
      if (exp_iv) begin
        n_cmp++;
        if ({inst_pc, inst_data} !== {held_pc, held_data}) begin
          n_err++; $display("FAIL rnd_inst cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_pc, inst_data, held_pc, held_data);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1; mem_cnt = int'($urandom_range(3)); mem_data = $urandom;
      end
      if (outstanding) begin
        if (rv) begin
          outstanding = 0;
          if (live && !redirect_valid) begin
            held = 1; held_pc = req_addr; held_data = imem_resp_data; exp_pc = req_addr + 32'd4;
          end
        end
      end else if (held) begin
        if (redirect_valid || inst_ready) begin
          held = 0;
          if (!redirect_valid) delivered++;
        end
      end else if (exp_rv && imem_req_ready) begin
        outstanding = 1; live = 1; req_addr = exp_pc;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc; live = 0;
      end
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (delivered < 20) begin
      n_err++; $display("FAIL rnd_progress got=%0d exp>=20", delivered);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_req_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
